psg_audio_mixer: RTL and testbench
==================================

Name: psg_audio_mixer

Overview:
- Downstream of the two Mockingboard YM2149 instances (left PSG, right PSG).
- Consumes the six 8-bit log-to-linear channel outputs (CHANNEL_A/B/C of each PSG) on the PSG clock enable.
- Box-filter decimates each PSG's three-channel sum to an audio sample rate and scales it to signed 16-bit stereo PCM.
- Presents the result to the audio output path through a valid/ready handshake with a one-deep holding register.

Parameters:
- DECIM_LOG2, 5, log2 of the number of CE ticks averaged per output sample (N = 2^DECIM_LOG2); legal range 1..8.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- CE  in  1  PSG clock enable, the same strobe that drives the YM2149 CE
- MUTE  in  1  forces output samples to 0 while high
- L_A, L_B, L_C  in  8 each  left PSG CHANNEL_A/B/C
- R_A, R_B, R_C  in  8 each  right PSG CHANNEL_A/B/C
- SAMPLE_L  out  16  signed left sample
- SAMPLE_R  out  16  signed right sample
- SAMPLE_VALID  out  1  sample pair available
- SAMPLE_READY  in  1  consumer accepts the sample pair
- OVERRUN  out  1  sticky flag: an unaccepted sample was overwritten

Behaviour:
- Reset: SAMPLE_L/R=0, SAMPLE_VALID=0, OVERRUN=0, window counter=0, accumulators=0, pipeline regs=0.
- Reset mid-window discards the partial window; the next sample needs a full N CE ticks after RESET deasserts.
- Per CE cycle, form sums sL=L_A+L_B+L_C and sR=R_A+R_B+R_C:
  - Each sum is 10-bit unsigned, max 765.
  - Each sum is added to its accumulator, 10+DECIM_LOG2 bits wide; no overflow is possible.
- Window counter counts CE ticks 0..N-1 and wraps.
- Stage 1, cycle T = CE cycle with counter==N-1:
  - avgX <= (accX + sX) >> DECIM_LOG2, 10 bits.
  - accX <= 0; counter <= 0; pend <= 1.
- Stage 2, cycle T+1, when pend=1:
  - xX = avgX*85 - 32768, implemented as shift-add: (u<<6)+(u<<4)+(u<<2)+u.
  - Range of xX is -32768..32257.
  - If MUTE=1 in cycle T+1, the loaded value is 0.
  - SAMPLE_L/R <= value; SAMPLE_VALID <= 1; pend <= 0.
- Latency: SAMPLE_VALID rises at T+2 relative to the terminating CE cycle (registered at end of T+1).
- Accumulation continues unaffected during stage 2, including when CE is high every clock.
- CE low: no state changes except the handshake and stage-2 completion.
- Handshake:
  - A transfer occurs on any cycle with VALID&READY.
  - VALID deasserts the next cycle unless a new stage-2 load occurs in the same cycle; a new load wins and VALID stays 1.
  - While VALID=1, SAMPLE_L/R are stable until a transfer or an overwrite.
- Overwrite: a stage-2 load while VALID=1 and READY=0 replaces the sample and sets OVERRUN=1. OVERRUN clears only on RESET.
- READY high with VALID low has no effect.

Optional Feature:
- Macro: PSG_MIX_DCBLOCK_EN.
- With the macro defined, a stage 3 one-pole DC blocker runs at sample rate on each channel:
  - y = x - x_prev + y_prev - (y_prev >>> 8).
  - Internal width is 18-bit signed; the result saturates to 16 bits.
  - x_prev and y_prev update with the pre-saturation values.
  - Reset values: x_prev = -32768, y_prev = 0.
  - MUTE is applied after the filter; filter state still updates while muted.
  - SAMPLE_VALID latency becomes T+3.
- Without the macro: no stage 3, latency is T+2, and the output is the DC-offset value xX.

Test Plan:
- All six inputs 0xFF, DECIM_LOG2=5, CE every clock, READY=1 -> first VALID 2 clocks after the 32nd CE; SAMPLE_L=SAMPLE_R=0x7E01 (32257).
- All inputs 0x00 -> SAMPLE_L/R=0x8000. Set MUTE=1 -> outputs 0x0000 from the next sample on.
- L_A=0xFF for 16 CE then 0x00 for 16 CE, other inputs 0 -> avg=127, SAMPLE_L=-21973 (0xAA2B), SAMPLE_R=0x8000.
- READY=0 across two windows -> VALID stays 1, second sample replaces the first, OVERRUN=1. READY=1 for one cycle -> VALID=0 the next cycle; OVERRUN stays 1.
- RESET asserted after 10 CEs of a window -> outputs 0, VALID 0; the next VALID occurs only after 32 further CEs.
- PSG_MIX_DCBLOCK_EN defined, inputs step from 0x00 to 0xFF -> first filtered sample saturates to 32767, then decays monotonically; |SAMPLE_L| < 256 within 2048 samples.

Source files
------------

// File: rtl/psg_audio_mixer.sv
// Stereo mixer for the two Mockingboard PSGs: box-filter decimation to 16-bit signed PCM
// behind a one-deep valid/ready register. Define PSG_MIX_DCBLOCK_EN to add a DC-blocking stage.
module psg_audio_mixer #(
    parameter int DECIM_LOG2 = 5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CE,
    input  logic        MUTE,
    input  logic [7:0]  L_A,
    input  logic [7:0]  L_B,
    input  logic [7:0]  L_C,
    input  logic [7:0]  R_A,
    input  logic [7:0]  R_B,
    input  logic [7:0]  R_C,
    output logic [15:0] SAMPLE_L,
    output logic [15:0] SAMPLE_R,
    output logic        SAMPLE_VALID,
    input  logic        SAMPLE_READY,
    output logic        OVERRUN
);

    localparam int ACC_W = 10 + DECIM_LOG2;

    logic [DECIM_LOG2-1:0] win_cnt;
    logic [ACC_W-1:0]      acc_l, acc_r;
    logic [ACC_W-1:0]      tot_l, tot_r;
    logic [9:0]            sum_l, sum_r;
    logic [9:0]            avg_l, avg_r;
    logic                  pend;
    logic                  win_end;
    logic                  load;
    logic [15:0]           load_l, load_r;

    // avg*85 - 32768 via shift-add; the product never exceeds 17 bits
    function automatic logic [15:0] to_pcm(input logic [9:0] u);
        logic [16:0] p;
        p = {1'b0, u, 6'b0} + {3'b0, u, 4'b0} + {5'b0, u, 2'b0} + {7'b0, u};
        return 16'(p - 17'd32768);
    endfunction

    assign sum_l   = {2'b0, L_A} + {2'b0, L_B} + {2'b0, L_C};
    assign sum_r   = {2'b0, R_A} + {2'b0, R_B} + {2'b0, R_C};
    assign tot_l   = acc_l + ACC_W'(sum_l);
    assign tot_r   = acc_r + ACC_W'(sum_r);
    assign win_end = CE && (&win_cnt);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            win_cnt <= '0;
            acc_l   <= '0;
            acc_r   <= '0;
            avg_l   <= '0;
            avg_r   <= '0;
        end else if (CE) begin
            win_cnt <= win_cnt + 1'b1;
            if (win_end) begin
                avg_l <= 10'(tot_l >> DECIM_LOG2);
                avg_r <= 10'(tot_r >> DECIM_LOG2);
                acc_l <= '0;
                acc_r <= '0;
            end else begin
                acc_l <= tot_l;
                acc_r <= tot_r;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            pend <= 1'b0;
        else if (win_end)
            pend <= 1'b1;
        else if (pend)
            pend <= 1'b0;
    end

`ifdef PSG_MIX_DCBLOCK_EN
    logic        pend2;
    logic [15:0] x_l, x_r;
    logic signed [17:0] xp_l, xp_r, yp_l, yp_r, y_l, y_r;

    function automatic logic signed [17:0] dc_step(input logic [15:0] x,
                                                   input logic signed [17:0] xp,
                                                   input logic signed [17:0] yp);
        return {{2{x[15]}}, x} - xp + yp - (yp >>> 8);
    endfunction

    function automatic logic [15:0] sat16(input logic signed [17:0] y);
        if (y > 18'sd32767)
            return 16'h7FFF;
        else if (y < -18'sd32768)
            return 16'h8000;
        else
            return y[15:0];
    endfunction

    assign y_l = dc_step(x_l, xp_l, yp_l);
    assign y_r = dc_step(x_r, xp_r, yp_r);

    // Filter history tracks the unsaturated result and keeps running while muted
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pend2 <= 1'b0;
            x_l   <= '0;
            x_r   <= '0;
            xp_l  <= -18'sd32768;
            xp_r  <= -18'sd32768;
            yp_l  <= '0;
            yp_r  <= '0;
        end else begin
            pend2 <= pend;
            if (pend) begin
                x_l <= to_pcm(avg_l);
                x_r <= to_pcm(avg_r);
            end
            if (pend2) begin
                xp_l <= {{2{x_l[15]}}, x_l};
                xp_r <= {{2{x_r[15]}}, x_r};
                yp_l <= y_l;
                yp_r <= y_r;
            end
        end
    end

    assign load   = pend2;
    assign load_l = MUTE ? 16'h0000 : sat16(y_l);
    assign load_r = MUTE ? 16'h0000 : sat16(y_r);
`else
    assign load   = pend;
    assign load_l = MUTE ? 16'h0000 : to_pcm(avg_l);
    assign load_r = MUTE ? 16'h0000 : to_pcm(avg_r);
`endif

    // A fresh load always wins over a transfer, so VALID never drops for a new sample
    always_ff @(posedge CLK) begin
        if (RESET) begin
            SAMPLE_L     <= '0;
            SAMPLE_R     <= '0;
            SAMPLE_VALID <= 1'b0;
            OVERRUN      <= 1'b0;
        end else if (load) begin
            SAMPLE_L     <= load_l;
            SAMPLE_R     <= load_r;
            SAMPLE_VALID <= 1'b1;
            if (SAMPLE_VALID && !SAMPLE_READY)
                OVERRUN <= 1'b1;
        end else if (SAMPLE_VALID && SAMPLE_READY) begin
            SAMPLE_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_psg_audio_mixer.sv
// Directed self-checking bench for psg_audio_mixer (DECIM_LOG2=5, 32 CE ticks per sample).
module tb_psg_audio_mixer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CE = 1'b0;
    logic        MUTE = 1'b0;
    logic [7:0]  L_A = '0, L_B = '0, L_C = '0;
    logic [7:0]  R_A = '0, R_B = '0, R_C = '0;
    logic [15:0] SAMPLE_L, SAMPLE_R;
    logic        SAMPLE_VALID;
    logic        SAMPLE_READY = 1'b1;
    logic        OVERRUN;

    int testsRun = 0;
    int failCount = 0;

    psg_audio_mixer #(.DECIM_LOG2(5)) dut (
        .CLK(CLK), .RESET(RESET), .CE(CE), .MUTE(MUTE),
        .L_A(L_A), .L_B(L_B), .L_C(L_C),
        .R_A(R_A), .R_B(R_B), .R_C(R_C),
        .SAMPLE_L(SAMPLE_L), .SAMPLE_R(SAMPLE_R),
        .SAMPLE_VALID(SAMPLE_VALID), .SAMPLE_READY(SAMPLE_READY),
        .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] la, input logic [7:0] lb, input logic [7:0] lc,
                                 input logic [7:0] ra, input logic [7:0] rb, input logic [7:0] rc);
        L_A = la; L_B = lb; L_C = lc;
        R_A = ra; R_B = rb; R_C = rc;
    endtask

    task automatic doReset();
        RESET = 1'b1;
        tick(2);
        RESET = 1'b0;
    endtask

    initial begin
`ifndef PSG_MIX_DCBLOCK_EN
        // Reset state
        doReset();
        checkOutput("reset_valid", 32'(SAMPLE_VALID), 32'd0);
        checkOutput("reset_l", 32'(SAMPLE_L), 32'h0);
        checkOutput("reset_r", 32'(SAMPLE_R), 32'h0);
        checkOutput("reset_ovr", 32'(OVERRUN), 32'd0);

        // Full scale, CE every clock: VALID two clocks after the 32nd CE
        applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        CE = 1'b1;
        SAMPLE_READY = 1'b1;
        tick(32);
        checkOutput("fs_not_yet_valid", 32'(SAMPLE_VALID), 32'd0);
        tick(1);
        checkOutput("fs_valid", 32'(SAMPLE_VALID), 32'd1);
        checkOutput("fs_l", 32'(SAMPLE_L), 32'h7E01);
        checkOutput("fs_r", 32'(SAMPLE_R), 32'h7E01);
        tick(1);
        checkOutput("fs_valid_drop", 32'(SAMPLE_VALID), 32'd0);

        // Silence, then mute
        doReset();
        applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        tick(33);
        checkOutput("zero_valid", 32'(SAMPLE_VALID), 32'd1);
        checkOutput("zero_l", 32'(SAMPLE_L), 32'h8000);
        checkOutput("zero_r", 32'(SAMPLE_R), 32'h8000);
        MUTE = 1'b1;
        tick(32);
        checkOutput("mute_valid", 32'(SAMPLE_VALID), 32'd1);
        checkOutput("mute_l", 32'(SAMPLE_L), 32'h0000);
        checkOutput("mute_r", 32'(SAMPLE_R), 32'h0000);
        MUTE = 1'b0;

        // Half-window pulse on L_A: avg 127 -> -21973
        doReset();
        applyStimulus(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        tick(16);
        applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        tick(16);
        tick(1);
        checkOutput("half_valid", 32'(SAMPLE_VALID), 32'd1);
        checkOutput("half_l", 32'(SAMPLE_L), 32'hAA2B);
        checkOutput("half_r", 32'(SAMPLE_R), 32'h8000);

        // Overwrite with READY low
        doReset();
        SAMPLE_READY = 1'b0;
        applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        tick(32);
        applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        tick(1);
        checkOutput("ovr_first_l", 32'(SAMPLE_L), 32'h8000);
        checkOutput("ovr_first_flag", 32'(OVERRUN), 32'd0);
        tick(31);
        checkOutput("ovr_hold_valid", 32'(SAMPLE_VALID), 32'd1);
        checkOutput("ovr_hold_l", 32'(SAMPLE_L), 32'h8000);
        tick(1);
        checkOutput("ovr_second_l", 32'(SAMPLE_L), 32'h7E01);
        checkOutput("ovr_second_r", 32'(SAMPLE_R), 32'h7E01);
        checkOutput("ovr_flag", 32'(OVERRUN), 32'd1);
        SAMPLE_READY = 1'b1;
        tick(1);
        checkOutput("ovr_xfer_valid", 32'(SAMPLE_VALID), 32'd0);
        checkOutput("ovr_sticky", 32'(OVERRUN), 32'd1);
        tick(2);
        checkOutput("ready_idle_valid", 32'(SAMPLE_VALID), 32'd0);

        // Reset after 10 CEs discards the partial window
        doReset();
        applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        tick(32);
        tick(1);
        tick(10);
        RESET = 1'b1;
        tick(1);
        checkOutput("mid_reset_l", 32'(SAMPLE_L), 32'h0);
        checkOutput("mid_reset_valid", 32'(SAMPLE_VALID), 32'd0);
        checkOutput("mid_reset_ovr", 32'(OVERRUN), 32'd0);
        RESET = 1'b0;
        tick(32);
        checkOutput("mid_reset_wait", 32'(SAMPLE_VALID), 32'd0);
        tick(1);
        checkOutput("mid_reset_valid2", 32'(SAMPLE_VALID), 32'd1);
        checkOutput("mid_reset_l2", 32'(SAMPLE_L), 32'h7E01);

        // CE every other clock: only CE ticks count
        doReset();
        applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 32; i++) begin
            CE = 1'b1;
            tick(1);
            CE = 1'b0;
            if (i == 31)
                checkOutput("gap_not_yet_valid", 32'(SAMPLE_VALID), 32'd0);
            tick(1);
        end
        checkOutput("gap_valid", 32'(SAMPLE_VALID), 32'd1);
        checkOutput("gap_l", 32'(SAMPLE_L), 32'h7E01);
        checkOutput("gap_r", 32'(SAMPLE_R), 32'h8000);
`else
        begin
            int prevS;
            int curS;
            logic mono;
            logic reached;
            doReset();
            checkOutput("reset_valid", 32'(SAMPLE_VALID), 32'd0);
            checkOutput("reset_l", 32'(SAMPLE_L), 32'h0);
            applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
            CE = 1'b1;
            SAMPLE_READY = 1'b1;
            tick(32);
            applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
            tick(1);
            checkOutput("dc_not_yet_valid", 32'(SAMPLE_VALID), 32'd0);
            tick(1);
            checkOutput("dc_first_valid", 32'(SAMPLE_VALID), 32'd1);
            checkOutput("dc_first_l", 32'(SAMPLE_L), 32'h0000);
            tick(32);
            checkOutput("dc_step_valid", 32'(SAMPLE_VALID), 32'd1);
            checkOutput("dc_step_l", 32'(SAMPLE_L), 32'h7FFF);
            checkOutput("dc_step_r", 32'(SAMPLE_R), 32'h7FFF);
            prevS = 32767;
            mono = 1'b1;
            reached = 1'b0;
            for (int n = 0; n < 2048 && !reached; n++) begin
                tick(32);
                curS = int'($signed(SAMPLE_L));
                if (curS > prevS)
                    mono = 1'b0;
                prevS = curS;
                if (curS < 256 && curS > -256)
                    reached = 1'b1;
            end
            checkOutput("dc_monotonic", 32'(mono), 32'd1);
            checkOutput("dc_settled", 32'(reached), 32'd1);
        end
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
